// File: rtl/cntr_pkg.sv
// Shared types and constants for the DSP-slice style loadable counter.
package cntr_pkg;

    // Default counter / load-data width
    localparam int CNTR_W = 48;

    // Values the registers take on reset; the count starts upward
    localparam logic [CNTR_W-1:0] CNTR_RST    = '0;
    localparam logic              ADD_SUB_RST = 1'b1;

    // What the P register will do on the next edge
    typedef enum logic [1:0] {
        MODE_LOAD = 2'd0,
        MODE_UP   = 2'd1,
        MODE_DOWN = 2'd2
    } mode_e;

    // LOAD wins over direction; direction only matters while counting
    function automatic mode_e decodeMode(input logic load, input logic addSub);
        mode_e mode;
        if (load) begin
            mode = MODE_LOAD;
        end else if (addSub) begin
            mode = MODE_UP;
        end else begin
            mode = MODE_DOWN;
        end
        return mode;
    endfunction

endpackage

// File: rtl/cntr_load_alu.sv
// Next-value selection for the counter: load the C value, or step up/down
// by STEP with unsigned wrap-around.
module cntr_load_alu
    import cntr_pkg::*;
#(
    parameter int WIDTH = CNTR_W,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] cntr_i,
    input  logic [WIDTH-1:0] cVal_i,
    input  logic             load_i,
    input  logic             addSub_i,
    output logic [WIDTH-1:0] next_o
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    mode_e mode;

    // Pick load/up/down; the C value is only looked at when loading, so a
    // garbage C input cannot leak into the count
    always_comb begin
        next_o = cntr_i;
        mode   = decodeMode(load_i, addSub_i);
        case (mode)
            MODE_LOAD: next_o = cVal_i;
            MODE_UP:   next_o = cntr_i + STEP_W;
            MODE_DOWN: next_o = cntr_i - STEP_W;
            default:   next_o = cntr_i;
        endcase
    end

endmodule

// File: rtl/cntr_load.sv
// Loadable up/down counter in DSP48E style: optional input register stage
// (C / OPMODE / ALUMODE equivalents) feeding a single P register.
module cntr_load
    import cntr_pkg::*;
#(
    parameter int WIDTH      = CNTR_W,
    parameter int REG_INPUTS = 1,
    parameter int STEP       = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] C_IN,
    input  logic             LOAD,
    input  logic             ADD_SUB,
    output logic [WIDTH-1:0] CNTR_OUT
);

    logic [WIDTH-1:0] cIn_q;
    logic             load_q;
    logic             addSub_q;
    logic [WIDTH-1:0] cntr_q;
    logic [WIDTH-1:0] cntr_d;

    generate
        if (REG_INPUTS != 0) begin : gen_inReg
            // Input stage: controls and load data registered once; reset drops any pending load
            always_ff @(posedge CLK) begin
                if (RST) begin
                    cIn_q    <= '0;
                    load_q   <= 1'b0;
                    addSub_q <= ADD_SUB_RST;
                end else begin
                    cIn_q    <= C_IN;
                    load_q   <= LOAD;
                    addSub_q <= ADD_SUB;
                end
            end
        end else begin : gen_inComb
            assign cIn_q    = C_IN;
            assign load_q   = LOAD;
            assign addSub_q = ADD_SUB;
        end
    endgenerate

    cntr_load_alu #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_alu (
        .cntr_i   (cntr_q),
        .cVal_i   (cIn_q),
        .load_i   (load_q),
        .addSub_i (addSub_q),
        .next_o   (cntr_d)
    );

    // P register: takes the ALU result every edge unless reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            cntr_q <= WIDTH'(CNTR_RST);
        end else begin
            cntr_q <= cntr_d;
        end
    end

    assign CNTR_OUT = cntr_q;

endmodule

// File: tb/tb_cntr_load.sv
// Self-checking bench for cntr_load (WIDTH=48, REG_INPUTS=1, STEP=1).
module tb_cntr_load;

    localparam int W = 48;
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    logic         CLK;
    logic         RST;
    logic [W-1:0] C_IN;
    logic         LOAD;
    logic         ADD_SUB;
    logic [W-1:0] CNTR_OUT;

    int checks;
    int failures;

    // Reference model: the count, plus the command presented one edge ago
    typedef struct {
        bit           load;
        bit           up;
        logic [W-1:0] c;
    } cmd_t;

    logic [W-1:0] expCount;
    cmd_t         prevCmd;

    cntr_load #(
        .WIDTH      (W),
        .REG_INPUTS (1),
        .STEP       (1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .C_IN     (C_IN),
        .LOAD     (LOAD),
        .ADD_SUB  (ADD_SUB),
        .CNTR_OUT (CNTR_OUT)
    );

    // Free-running 10 ns clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [W-1:0] rand48();
        return {16'($urandom), $urandom};
    endfunction

    // Present one set of inputs, advance one edge, update the model, settle
    task automatic applyStimulus(input bit rst, input logic [W-1:0] c, input bit ld, input bit up);
        RST     = rst;
        C_IN    = c;
        LOAD    = ld;
        ADD_SUB = up;
        @(posedge CLK);
        if (rst) begin
            expCount = '0;
            prevCmd  = '{load: 1'b0, up: 1'b1, c: '0};
        end else begin
            if (prevCmd.load)    expCount = prevCmd.c;
            else if (prevCmd.up) expCount = expCount + 1;
            else                 expCount = expCount - 1;
            prevCmd = '{load: ld, up: up, c: c};
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, rand48(), 1'($urandom), 1'($urandom));
            checks++;
            if (CNTR_OUT !== '0) begin
                failures++;
                $display("[TB] FAIL reset_hold got=%h exp=%h", CNTR_OUT, 48'h0);
            end
        end
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, rand48(), 1'b0, 1'b1);
            checks++;
            if (CNTR_OUT !== W'(i) || CNTR_OUT !== expCount) begin
                failures++;
                $display("[TB] FAIL reset_release got=%h exp=%h", CNTR_OUT, W'(i));
            end
        end
    endtask

    task automatic test_load_up();
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b0, W'(512), 1'b1, 1'b1);
            checks++;
            if (CNTR_OUT !== expCount || (i >= 2 && CNTR_OUT !== W'(48'h200))) begin
                failures++;
                $display("[TB] FAIL load_up_hold got=%h exp=%h", CNTR_OUT, expCount);
            end
        end
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b0, W'(2020), 1'b0, 1'b1);
            checks++;
            if (CNTR_OUT !== expCount || CNTR_OUT !== W'(48'h200 + k - 1)) begin
                failures++;
                $display("[TB] FAIL load_up_count got=%h exp=%h", CNTR_OUT, W'(48'h200 + k - 1));
            end
        end
    endtask

    task automatic test_load_down();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, W'(2020), 1'b1, 1'b0);
            checks++;
            if (CNTR_OUT !== expCount || (i >= 2 && CNTR_OUT !== W'(48'h7E4))) begin
                failures++;
                $display("[TB] FAIL load_down_hold got=%h exp=%h", CNTR_OUT, expCount);
            end
        end
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b0, rand48(), 1'b0, 1'b0);
            checks++;
            if (CNTR_OUT !== expCount || CNTR_OUT !== W'(48'h7E4 - k + 1)) begin
                failures++;
                $display("[TB] FAIL load_down_count got=%h exp=%h", CNTR_OUT, W'(48'h7E4 - k + 1));
            end
        end
    endtask

    task automatic test_wrap();
        applyStimulus(1'b0, ALL_ONES, 1'b1, 1'b1);
        applyStimulus(1'b0, ALL_ONES, 1'b1, 1'b1);
        applyStimulus(1'b0, rand48(), 1'b0, 1'b1);
        applyStimulus(1'b0, rand48(), 1'b0, 1'b1);
        checks++;
        if (CNTR_OUT !== '0 || CNTR_OUT !== expCount) begin
            failures++;
            $display("[TB] FAIL wrap_up got=%h exp=%h", CNTR_OUT, 48'h0);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, rand48(), 1'b0, 1'b0);
        applyStimulus(1'b0, rand48(), 1'b0, 1'b0);
        checks++;
        if (CNTR_OUT !== ALL_ONES || CNTR_OUT !== expCount) begin
            failures++;
            $display("[TB] FAIL wrap_down got=%h exp=%h", CNTR_OUT, ALL_ONES);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, rand48(), 1'b0, 1'b0);
        // load is now captured in the input register but not yet in P
        applyStimulus(1'b0, W'(48'h1234_5678_9ABC), 1'b1, 1'b1);
        applyStimulus(1'b1, W'(48'h1234_5678_9ABC), 1'b1, 1'b1);
        checks++;
        if (CNTR_OUT !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid got=%h exp=%h", CNTR_OUT, 48'h0);
        end
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, rand48(), 1'b0, 1'b1);
            checks++;
            if (CNTR_OUT !== W'(i) || CNTR_OUT !== expCount) begin
                failures++;
                $display("[TB] FAIL reset_mid_resume got=%h exp=%h", CNTR_OUT, W'(i));
            end
        end
    endtask

    task automatic test_toggle();
        logic [W-1:0] last;
        bit           dir;
        last = CNTR_OUT;
        dir  = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i % 3 == 0) dir = ~dir;
            applyStimulus(1'b0, rand48(), 1'b0, dir);
            checks++;
            if (CNTR_OUT !== expCount ||
                (CNTR_OUT !== last + 1 && CNTR_OUT !== last - 1)) begin
                failures++;
                $display("[TB] FAIL toggle_step got=%h exp=%h", CNTR_OUT, expCount);
            end
            last = CNTR_OUT;
        end
    endtask

    task automatic test_random();
        bit rst;
        bit ld;
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 19) == 0);
            ld  = ($urandom_range(0, 7) == 0);
            applyStimulus(rst, rand48(), ld, 1'($urandom));
            checks++;
            if (CNTR_OUT !== expCount) begin
                failures++;
                $display("[TB] FAIL random got=%h exp=%h", CNTR_OUT, expCount);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RST      = 1'b1;
        C_IN     = '0;
        LOAD     = 1'b0;
        ADD_SUB  = 1'b1;
        expCount = '0;
        prevCmd  = '{load: 1'b0, up: 1'b1, c: '0};

        test_reset();
        test_load_up();
        test_load_down();
        test_wrap();
        test_reset_mid();
        test_toggle();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
